// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, redirect,
// mul/div and imem-wait handling plus saturating stall/redirect counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic             mem_read_EX,
  input  logic [4:0]       rd_EX,
  input  logic             branch_taken_EX,
  input  logic             md_start_EX,
  input  logic             md_done,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             md_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int unsigned FL_W = 3;
  localparam int unsigned MD_W = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FL_W-1:0] flush_q, flush_d;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            lu_hazard;
  logic            md_expired;
  logic            md_exit;

  assign lu_hazard  = mem_read_EX && (rd_EX != 5'd0) &&
                      ((uses_rs1_ID && (rs1_ID == rd_EX)) ||
                       (uses_rs2_ID && (rs2_ID == rd_EX)));
  assign md_expired = !md_done && (md_cnt_q == MD_W'(MD_TIMEOUT - 1));
  assign md_exit    = md_done || md_expired;
  assign state      = 2'(state_q);

  // State and sequencing counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      flush_q  <= '0;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state logic; branch wins over a simultaneous md_start
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (branch_taken_EX) begin
          if (BR_PENALTY > 0) begin
            state_d = ST_FLUSH;
            flush_d = FL_W'(BR_PENALTY);
          end
        end else if (md_start_EX) begin
          state_d  = ST_MD_WAIT;
          md_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (imem_ready) begin
          flush_d = flush_q - FL_W'(1);
          if (flush_q <= FL_W'(1)) state_d = ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        if (md_exit) state_d = ST_RUN;
        else         md_cnt_d = md_cnt_q + MD_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Zero-latency pipeline controls
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    if (!reset_n) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken_EX) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (md_start_EX) begin
            ex_hold = 1'b1;
          end else if (lu_hazard) begin
            id_ex_bubble = 1'b1;
          end else if (!imem_ready) begin
            if_id_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_write    = imem_ready;
          if_id_flush = 1'b1;
        end
        ST_MD_WAIT: ex_hold = !md_exit;
        default: ;
      endcase
    end
  end

  // Sticky timeout flag and saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      md_timeout   <= 1'b0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if ((state_q == ST_MD_WAIT) && md_expired) md_timeout <= 1'b1;
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state_q == ST_RUN) && branch_taken_EX && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the PC write enable, the IF/ID register write enable and flush, the ID/EX bubble insert, and the EX hold for multi-cycle mul/div.
- Resolves load-use hazards, taken-branch redirects, mul/div busy periods and instruction-memory wait states.
- Keeps saturating performance counters for stall cycles and redirects.

Parameters:
- BR_PENALTY, 1: extra cycles after a redirect during which IF/ID is flushed. Range 0..7; 0 disables the FLUSH state.
- MD_TIMEOUT, 64: maximum MD_WAIT cycles before forced exit. Range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- rs1_ID  in  5  rs1 field of the instruction in ID
- rs2_ID  in  5  rs2 field of the instruction in ID
- uses_rs1_ID  in  1  the ID instruction reads rs1
- uses_rs2_ID  in  1  the ID instruction reads rs2
- mem_read_EX  in  1  the EX instruction is a load
- rd_EX  in  5  destination of the EX instruction
- branch_taken_EX  in  1  branch/jump redirect resolved in EX this cycle
- md_start_EX  in  1  multi-cycle mul/div starts in EX this cycle
- md_done  in  1  mul/div result valid
- imem_ready  in  1  instruction memory returned a valid word this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF_ID write enable
- if_id_flush  out  1  IF_ID flush; overrides write
- id_ex_bubble  out  1  zero the ID/EX control fields
- ex_hold  out  1  freeze the ID/EX and EX/MEM registers
- md_timeout  out  1  sticky: an MD_WAIT exit was caused by timeout
- state  out  2  0 = RUN, 1 = FLUSH, 2 = MD_WAIT
- stall_cnt  out  CNT_W  cycles with pc_write = 0 outside reset; saturating
- redirect_cnt  out  CNT_W  accepted branch redirects; saturating

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - Registered values: state = RUN, internal counters = 0, md_timeout = 0, stall_cnt = 0, redirect_cnt = 0.
  - Combinational outputs while reset_n = 0: pc_write = 0, if_id_write = 0, if_id_flush = 1, id_ex_bubble = 1, ex_hold = 0.
  - Reset overrides every state, including a reset in the middle of MD_WAIT or FLUSH.
- Output timing: control outputs are combinational from state and the current inputs. Zero-latency response is required so that the IF_ID / ID_EX registers act on the same edge.
- lu_hazard = mem_read_EX & (rd_EX != 0) & ((uses_rs1_ID & rs1_ID == rd_EX) | (uses_rs2_ID & rs2_ID == rd_EX)).
- RUN state: evaluate conditions in this priority order.
  1. branch_taken_EX:
     - Outputs: pc_write = 1, if_id_flush = 1, id_ex_bubble = 1, if_id_write = 1.
     - redirect_cnt increments.
     - If BR_PENALTY > 0: go to FLUSH and load the flush counter with BR_PENALTY. Otherwise stay in RUN.
     - lu_hazard and imem_ready are ignored this cycle.
  2. md_start_EX:
     - Outputs: pc_write = 0, if_id_write = 0, ex_hold = 1, id_ex_bubble = 0.
     - Go to MD_WAIT and clear the timeout counter.
  3. lu_hazard:
     - Outputs: pc_write = 0, if_id_write = 0, if_id_flush = 0, id_ex_bubble = 1.
     - Stay in RUN. The hazard clears naturally next cycle because EX then holds the bubble.
  4. imem_ready = 0:
     - Outputs: pc_write = 0, if_id_flush = 1, id_ex_bubble = 0.
  5. Otherwise:
     - Outputs: pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_bubble = 0, ex_hold = 0.
- FLUSH state:
  - Outputs: pc_write = imem_ready, if_id_flush = 1, id_ex_bubble = 0.
  - The flush counter decrements only when imem_ready = 1. Go to RUN on the cycle it reaches 0 after decrementing.
  - branch_taken_EX, md_start_EX and lu_hazard are ignored, since EX holds a bubble.
- MD_WAIT state:
  - While waiting: pc_write = 0, if_id_write = 0, ex_hold = 1. The timeout counter increments.
  - On md_done = 1: ex_hold = 0, pc_write = 0, if_id_write = 0 for this cycle, then go to RUN. The hazard conditions are re-evaluated in RUN next cycle.
  - Timeout: when the counter reaches MD_TIMEOUT - 1 without md_done, set md_timeout (sticky until reset) and act exactly as on md_done.
  - branch_taken_EX is ignored in this state.
- Counters:
  - stall_cnt increments in every non-reset cycle where pc_write = 0.
  - Both counters saturate at all-ones and never wrap.
- Illegal condition: branch_taken_EX & md_start_EX together. Branch wins and md_start_EX is dropped. This is covered by an assertion in the bench.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles, including once entered from MD_WAIT → state = 0, stall_cnt = 0, if_id_flush = 1, pc_write = 0 throughout.
- Load-use: mem_read_EX = 1, rd_EX = 5, rs2_ID = 5, uses_rs2_ID = 1 for one cycle → pc_write = 0, if_id_write = 0, id_ex_bubble = 1 for exactly 1 cycle; stall_cnt = 1. Repeat with rd_EX = 0 → no stall.
- Branch with BR_PENALTY = 1: branch_taken_EX for 1 cycle → cycle 0: flush + bubble + pc_write; cycle 1: FLUSH, if_id_flush = 1; cycle 2: RUN; redirect_cnt = 1.
- Mul/div: md_start_EX, then md_done 5 cycles later → ex_hold = 1 for 5 cycles, 0 on the done cycle; RUN next cycle; stall_cnt = 6; md_timeout = 0.
- Timeout with MD_TIMEOUT = 8: md_start_EX, md_done never asserted → exit after 8 cycles; md_timeout = 1 and stays 1 until reset.
- Priority and saturation:
  - branch_taken_EX, lu_hazard and imem_ready = 0 in the same cycle → branch behaviour only.
  - With CNT_W = 4, 20 stall cycles → stall_cnt = 15.
